// File: rtl/procesador_pkg.sv
`default_nettype none
// ============================================================================
// Module : procesador_pkg
// Brief  : Shared types and opcode constants for the processor data path.
// Rev    : 1.0 - initial release
// ============================================================================
package procesador_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } arb_owner_t;

    localparam logic [3:0] OP_LD = 4'b1100;
    localparam logic [3:0] OP_ST = 4'b1101;

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module : arb_starve_cnt
// Brief  : Saturating count of consecutive cycles a request was denied.
// Rev    : 1.0 - initial release
// ============================================================================
module arb_starve_cnt #(
    parameter int STARVE_LIM = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic at_limit
);

    localparam logic [3:0] c_lim = 4'(STARVE_LIM);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (!req || gnt) begin
            r_cnt <= 4'd0;
        end else if (r_cnt != c_lim) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign at_limit = (r_cnt == c_lim);

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : data_mem_arbiter
// Brief  : Shares the single-port data memory between CPU MEM stage and the
//          external filter-data port; CPU priority with starvation override.
// Rev    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import procesador_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [2:0] c_lat = 3'(MEM_LAT);

    arb_state_t r_state, w_next_state;
    arb_owner_t r_owner, w_next_owner;
    logic [2:0] r_lat_cnt, w_next_lat;

    logic w_cpu_req;
    logic w_ext_win;
    logic w_cpu_done;
    logic w_at_limit;

    assign w_cpu_req = cpu_re | cpu_we;

    arb_starve_cnt #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (ext_req),
        .gnt      (ext_gnt),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_owner   <= OWN_CPU;
            r_lat_cnt <= 3'd0;
        end else begin
            r_state   <= w_next_state;
            r_owner   <= w_next_owner;
            r_lat_cnt <= w_next_lat;
        end
    end

    // Outputs are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_lat   = r_lat_cnt;
        w_ext_win    = 1'b0;
        w_cpu_done   = 1'b0;
        cpu_rdata    = '0;
        cpu_stall    = 1'b0;
        ext_gnt      = 1'b0;
        ext_rvalid   = 1'b0;
        ext_rdata    = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    w_ext_win = ext_req && (w_at_limit || !w_cpu_req);
                    if (w_ext_win) begin
                        ext_gnt   = 1'b1;
                        mem_addr  = ext_addr;
                        mem_wdata = ext_wdata;
                        mem_we    = ext_we;
                        mem_re    = !ext_we;
                        if (!ext_we) begin
                            w_next_state = RD_WAIT;
                            w_next_owner = OWN_EXT;
                            w_next_lat   = 3'd1;
                        end
                    end else if (w_cpu_req) begin
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                        // A simultaneous read+write request is treated as a write.
                        mem_we    = cpu_we;
                        mem_re    = !cpu_we;
                        if (cpu_we) begin
                            w_cpu_done = 1'b1;
                        end else begin
                            w_next_state = RD_WAIT;
                            w_next_owner = OWN_CPU;
                            w_next_lat   = 3'd1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_lat_cnt == c_lat) begin
                        w_next_state = IDLE;
                        w_next_lat   = 3'd0;
                        if (r_owner == OWN_CPU) begin
                            cpu_rdata  = mem_rdata;
                            w_cpu_done = 1'b1;
                        end else begin
                            ext_rdata  = mem_rdata;
                            ext_rvalid = 1'b1;
                        end
                    end else begin
                        w_next_lat = r_lat_cnt + 3'd1;
                    end
                end
                default: w_next_state = IDLE;
            endcase
            cpu_stall = w_cpu_req && !w_cpu_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_arbiter
// Brief  : Directed self-checking bench for data_mem_arbiter (MEM_LAT=2, STARVE_LIM=3).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_re, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [15:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_re, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    data_mem_arbiter #(
        .ADDR_W(16), .DATA_W(32), .MEM_LAT(2), .STARVE_LIM(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; checks run 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; mem_rdata = 32'hFFFF_FFFF;
        #2;
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        cpu_re = 1'b0; ext_req = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // CPU load 0x0010
        cpu_re = 1'b1; cpu_addr = 16'h0010; #1;
        chk("ld_mem_re_c0", {31'd0, mem_re}, 32'd1);
        chk("ld_mem_addr", {16'd0, mem_addr}, 32'h0010);
        chk("ld_stall_c0", {31'd0, cpu_stall}, 32'd1);
        chk("ld_rdata_c0", cpu_rdata, 32'd0);
        tick(); #1;
        chk("ld_mem_re_c1", {31'd0, mem_re}, 32'd0);
        chk("ld_stall_c1", {31'd0, cpu_stall}, 32'd1);
        tick(); mem_rdata = 32'hDEAD_BEEF; #1;
        chk("ld_stall_c2", {31'd0, cpu_stall}, 32'd0);
        chk("ld_rdata_c2", cpu_rdata, 32'hDEAD_BEEF);
        tick(); cpu_re = 1'b0; mem_rdata = '0; #1;
        chk("ld_after_re", {31'd0, mem_re}, 32'd0);

        // CPU store in idle, then read+write together (write wins)
        cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'h1234_5678; #1;
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr", {16'd0, mem_addr}, 32'h0020);
        chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
        chk("st_stall", {31'd0, cpu_stall}, 32'd0);
        tick(); cpu_re = 1'b1; #1;
        chk("rw_mem_we", {31'd0, mem_we}, 32'd1);
        chk("rw_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rw_stall", {31'd0, cpu_stall}, 32'd0);
        tick(); cpu_re = 1'b0; cpu_we = 1'b0;

        // External read 0x0040, CPU idle
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0040; #1;
        chk("ext_gnt_c0", {31'd0, ext_gnt}, 32'd1);
        chk("ext_mem_re_c0", {31'd0, mem_re}, 32'd1);
        chk("ext_mem_addr", {16'd0, mem_addr}, 32'h0040);
        chk("ext_stall_c0", {31'd0, cpu_stall}, 32'd0);
        tick(); ext_req = 1'b0; #1;
        chk("ext_gnt_c1", {31'd0, ext_gnt}, 32'd0);
        chk("ext_rvalid_c1", {31'd0, ext_rvalid}, 32'd0);
        tick(); mem_rdata = 32'hCAFE_F00D; #1;
        chk("ext_rvalid_c2", {31'd0, ext_rvalid}, 32'd1);
        chk("ext_rdata_c2", ext_rdata, 32'hCAFE_F00D);
        chk("ext_cpu_rdata", cpu_rdata, 32'd0);
        tick(); mem_rdata = '0; #1;
        chk("ext_rvalid_c3", {31'd0, ext_rvalid}, 32'd0);

        // Back-to-back CPU loads with ext write held: ext wins after 3 denials
        cpu_re = 1'b1; cpu_addr = 16'h0100; ext_req = 1'b1; ext_we = 1'b1;
        ext_addr = 16'h0044; ext_wdata = 32'hA5A5_A5A5; #1;
        chk("sv_c0_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("sv_c0_mem_re", {31'd0, mem_re}, 32'd1);
        tick(); #1;
        chk("sv_c1_gnt", {31'd0, ext_gnt}, 32'd0);
        tick(); mem_rdata = 32'h1111_1111; #1;
        chk("sv_c2_rdata", cpu_rdata, 32'h1111_1111);
        chk("sv_c2_gnt", {31'd0, ext_gnt}, 32'd0);
        tick(); cpu_addr = 16'h0104; mem_rdata = '0; #1;
        chk("sv_c3_gnt", {31'd0, ext_gnt}, 32'd1);
        chk("sv_c3_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sv_c3_mem_addr", {16'd0, mem_addr}, 32'h0044);
        chk("sv_c3_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sv_c3_stall", {31'd0, cpu_stall}, 32'd1);
        tick(); ext_req = 1'b0; ext_we = 1'b0; #1;
        chk("sv_c4_mem_re", {31'd0, mem_re}, 32'd1);
        chk("sv_c4_addr", {16'd0, mem_addr}, 32'h0104);
        chk("sv_c4_stall", {31'd0, cpu_stall}, 32'd1);
        tick(); tick(); mem_rdata = 32'h2222_2222; #1;
        chk("sv_c6_rdata", cpu_rdata, 32'h2222_2222);
        chk("sv_c6_stall", {31'd0, cpu_stall}, 32'd0);
        tick(); cpu_re = 1'b0; mem_rdata = '0;

        // Simultaneous CPU write and ext read at zero starvation
        cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 32'h0BAD_F00D;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0080; #1;
        chk("sim_mem_we", {31'd0, mem_we}, 32'd1);
        chk("sim_mem_addr", {16'd0, mem_addr}, 32'h0030);
        chk("sim_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("sim_stall", {31'd0, cpu_stall}, 32'd0);
        tick(); cpu_we = 1'b0; #1;
        chk("sim_starve", {28'd0, dut.u_starve.r_cnt}, 32'd1);
        chk("sim_ext_gnt_next", {31'd0, ext_gnt}, 32'd1);

        // Reset pulse while the ext read is in RD_WAIT
        tick(); ext_req = 1'b0; cpu_re = 1'b1; rst_n = 1'b0; #1;
        chk("rmr_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rmr_rvalid", {31'd0, ext_rvalid}, 32'd0);
        chk("rmr_mem_re", {31'd0, mem_re}, 32'd0);
        chk("rmr_mem_addr", {16'd0, mem_addr}, 32'd0);
        tick(); cpu_re = 1'b0; rst_n = 1'b1; mem_rdata = 32'h0BAD_0BAD; #1;
        chk("rmr_late_rvalid", {31'd0, ext_rvalid}, 32'd0);
        chk("rmr_late_rdata", ext_rdata, 32'd0);
        cpu_we = 1'b1; cpu_addr = 16'h0050; #1;
        chk("rmr_idle_we", {31'd0, mem_we}, 32'd1);
        chk("rmr_idle_stall", {31'd0, cpu_stall}, 32'd0);
        tick(); cpu_we = 1'b0; mem_rdata = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
